dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit words in the internal data array (power of two, minimum 4).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 req_valid  input  1  requester presents a load/store request.
REQ-005 req_ready  output  1  block can accept a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RISC-V size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  requester accepts response.
REQ-012 rsp_rdata  output  32  load result, extended per funct3; 0 for stores and errors.
REQ-013 rsp_err  output  1  request was rejected (misaligned, out of range, illegal funct3).

Function
REQ-014 FSM states IDLE, ACCESS, RESP; reset state IDLE.
REQ-015 req_ready = 1 only in IDLE; request accepted on rising edge with req_valid & req_ready; req_we, req_funct3, req_addr, req_wdata captured into internal registers at that edge.
REQ-016 IDLE -> ACCESS on accept; otherwise stay IDLE.
REQ-017 ACCESS -> RESP unconditionally after one cycle; array read or write occurs at the ACCESS->RESP edge using captured request only.
REQ-018 RESP: rsp_valid = 1, rsp_rdata/rsp_err held stable; RESP -> IDLE on edge with rsp_ready = 1; remain in RESP while rsp_ready = 0.
REQ-019 Latency: rsp_valid rises the second rising edge after accept; with rsp_ready tied high, one transaction per 3 cycles.
REQ-020 Word index = addr[log2(DEPTH_WORDS)+1:2]; byte lane = addr[1:0]; little-endian (byte 0 in bits [7:0]).
REQ-021 Error if addr >= 4*DEPTH_WORDS, or H/HU with addr[0] = 1, or W with addr[1:0] != 0, or funct3 in {011,110,111}, or store with funct3 in {100,101}.
REQ-022 Errored request: no array write, rsp_err = 1, rsp_rdata = 0, same latency as legal request.
REQ-023 SB writes only the addressed byte lane; SH writes only lanes {addr[1],0}/{addr[1],1}; SW writes all 4 lanes; other lanes unchanged.
REQ-024 LB/LH sign-extend selected byte/half to 32 bits; LBU/LHU zero-extend; LW returns full word.
REQ-025 Store response: rsp_valid = 1, rsp_err = 0 (if legal), rsp_rdata = 0.
REQ-026 Input changes while not in IDLE have no effect; req_valid held high in ACCESS/RESP is not accepted until return to IDLE.
REQ-027 Load following a store to the same word returns the updated data.
REQ-028 Array contents are not reset and are undefined until written.

Reset
REQ-029 On rst assertion, immediately: state IDLE, req_ready = 1 (once rst deasserts; 0 while rst high), rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, captured request registers cleared.
REQ-030 rst asserted in ACCESS before the ACCESS->RESP edge: no array write occurs; pending transaction discarded, no response issued.
REQ-031 rst asserted in RESP: response dropped; array write already performed is retained.

Verification
REQ-032 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_rdata 0xDEADBEEF, rsp_err 0, rsp_valid 2 cycles after each accept.
REQ-033 After REQ-032: SB 0x12 data 0x00000080; LB 0x12 -> 0xFFFFFF80; LBU 0x12 -> 0x00000080; LW 0x10 -> 0xDE80BEEF.
REQ-034 LH 0x13, SW 0x11, LW 0x400 (DEPTH_WORDS 256), funct3 011 -> rsp_err 1, rsp_rdata 0; subsequent LW 0x10 still returns 0xDE80BEEF.
REQ-035 Load with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable for 5 cycles, req_ready 0; IDLE one edge after rsp_ready = 1.
REQ-036 SW 0x20 data 0x12345678 with rst pulsed during ACCESS -> no response; later LW 0x20 returns previous contents (write suppressed); outputs 0 immediately on rst.

Source files
------------

// File: rtl/dmem_responder.sv
// Single-port data memory responder: load/store requests in, one response out.
// Ports: clk, rst, req_* (valid/ready request), rsp_* (valid/ready response).
module dmem_responder #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state, state_nx;

  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          oor;
  logic          bad;
  logic          err;
  logic [31:0]   word;
  logic [7:0]    bsel;
  logic [15:0]   hsel;
  logic [31:0]   ld;
  logic [3:0]    be;
  logic [31:0]   sdata;
  logic          wr_en;

  assign req_ready = (state == IDLE) & ~rst;
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign accept = req_valid & req_ready;
  assign idx    = addr_q[AW+1:2];
  assign lane   = addr_q[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = ACCESS;
      ACCESS:  state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Anything above the array, misaligned, or BU/HU used as a store.
  always_comb begin
    oor = |addr_q[31:AW+2];
    bad = 1'b1;
    unique case (f3_q)
      3'b000:  bad = 1'b0;
      3'b001:  bad = addr_q[0];
      3'b010:  bad = |addr_q[1:0];
      3'b100:  bad = we_q;
      3'b101:  bad = we_q | addr_q[0];
      default: bad = 1'b1;
    endcase
    err = oor | bad;
  end

  always_comb begin
    word = mem[idx];
    bsel = word[{lane, 3'b000} +: 8];
    hsel = addr_q[1] ? word[31:16] : word[15:0];
    ld   = 32'd0;
    unique case (f3_q)
      3'b000:  ld = {{24{bsel[7]}}, bsel};
      3'b001:  ld = {{16{hsel[15]}}, hsel};
      3'b010:  ld = word;
      3'b100:  ld = {24'd0, bsel};
      3'b101:  ld = {16'd0, hsel};
      default: ld = 32'd0;
    endcase
  end

  // Store data is replicated so every lane carries the right bytes;
  // the byte enables decide which lanes actually change.
  always_comb begin
    be    = 4'b0000;
    sdata = wdata_q;
    unique case (f3_q)
      3'b000: begin
        be    = 4'b0001 << lane;
        sdata = {4{wdata_q[7:0]}};
      end
      3'b001: begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        sdata = {2{wdata_q[15:0]}};
      end
      3'b010: begin
        be    = 4'b1111;
        sdata = wdata_q;
      end
      default: begin
        be    = 4'b0000;
        sdata = wdata_q;
      end
    endcase
  end

  // A reset in ACCESS forces IDLE asynchronously, so the write is lost.
  assign wr_en = (state == ACCESS) & we_q & ~err & ~rst;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= sdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (state == ACCESS) begin
      err_q   <= err;
      rdata_q <= (err | we_q) ? 32'd0 : ld;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a byte-array reference model.
// A negedge compare process checks handshake and response every cycle.
module tb_dmem_responder;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_responder #(.DEPTH_WORDS(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  logic        chk_en = 1'b0;
  logic        exp_rvalid = 1'b0;
  logic        exp_rready = 1'b0;
  logic [31:0] exp_rdata = 32'd0;
  logic        exp_err = 1'b0;

  logic [7:0] mm [4*DEPTH];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference: byte-addressed memory, RISC-V size/sign rules.
  task automatic model(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
    int n;
    logic [31:0] v;
    er = 1'b0;
    rd = 32'd0;
    n  = 0;
    if (a >= 32'(4*DEPTH)) er = 1'b1;
    case (f3)
      3'b000: n = 1;
      3'b001: begin n = 2; if (a % 2 != 0) er = 1'b1; end
      3'b010: begin n = 4; if (a % 4 != 0) er = 1'b1; end
      3'b100: begin n = 1; if (we) er = 1'b1; end
      3'b101: begin n = 2; if (we || a % 2 != 0) er = 1'b1; end
      default: er = 1'b1;
    endcase
    if (!er) begin
      if (we) begin
        for (int i = 0; i < n; i++) mm[int'(a) + i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(mm[int'(a) + i]) << (8*i));
        if (f3 == 3'b000 && v[7])  v = v | 32'hFFFFFF00;
        if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF0000;
        rd = v;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("rsp_valid", 32'(rsp_valid), 32'(exp_rvalid));
      check("req_ready", 32'(req_ready), 32'(exp_rready));
      if (exp_rvalid) begin
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
      end
    end
  end

  // Called at posedge+1 with the DUT idle. Junk is held on the request
  // port with req_valid high while busy; it must not be taken.
  task automatic txn(input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int stall,
                     output logic [31:0] rd, output logic er);
    model(we, f3, a, wd, rd, er);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    exp_rvalid = 1'b0;
    exp_rready = 1'b1;
    @(posedge clk); #1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h10;
    req_wdata  = 32'h55AA55AA;
    exp_rready = 1'b0;
    @(posedge clk); #1;
    exp_rvalid = 1'b1;
    exp_rdata  = rd;
    exp_err    = er;
    rsp_ready  = (stall == 0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (i == stall - 1) rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    req_valid  = 1'b0;
    rsp_ready  = 1'b0;
    exp_rvalid = 1'b0;
    exp_rready = 1'b1;
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    rsp_ready  = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    #11 rst = 1'b0;
    #1 check("post_rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    exp_rready = 1'b1;
    chk_en = 1'b1;

    txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, er);
    check("sw10_err", 32'(er), 32'd0);
    txn(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er);
    check("lw10_lit", rd, 32'hDEADBEEF);
    txn(1'b1, 3'b000, 32'h12, 32'h00000080, 0, rd, er);
    txn(1'b0, 3'b000, 32'h12, 32'h0, 0, rd, er);
    check("lb12_lit", rd, 32'hFFFFFF80);
    txn(1'b0, 3'b100, 32'h12, 32'h0, 0, rd, er);
    check("lbu12_lit", rd, 32'h00000080);
    txn(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er);
    check("lw10b_lit", rd, 32'hDE80BEEF);

    txn(1'b0, 3'b001, 32'h13, 32'h0, 0, rd, er);
    check("lh13_err_lit", 32'(er), 32'd1);
    txn(1'b1, 3'b010, 32'h11, 32'hFFFFFFFF, 0, rd, er);
    check("sw11_err_lit", 32'(er), 32'd1);
    txn(1'b0, 3'b010, 32'h400, 32'h0, 0, rd, er);
    check("lw400_err_lit", 32'(er), 32'd1);
    txn(1'b0, 3'b011, 32'h10, 32'h0, 0, rd, er);
    txn(1'b1, 3'b100, 32'h10, 32'h000000FF, 0, rd, er);
    check("sbu_err_lit", 32'(er), 32'd1);
    txn(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er);
    check("lw10c_lit", rd, 32'hDE80BEEF);

    txn(1'b0, 3'b001, 32'h12, 32'h0, 0, rd, er);
    check("lh12_lit", rd, 32'hFFFFDE80);
    txn(1'b0, 3'b101, 32'h10, 32'h0, 0, rd, er);
    check("lhu10_lit", rd, 32'h0000BEEF);
    txn(1'b0, 3'b000, 32'h13, 32'h0, 0, rd, er);
    check("lb13_lit", rd, 32'hFFFFFFDE);
    txn(1'b1, 3'b010, 32'h14, 32'h0, 0, rd, er);
    txn(1'b1, 3'b001, 32'h16, 32'h1234ABCD, 0, rd, er);
    txn(1'b0, 3'b010, 32'h14, 32'h0, 0, rd, er);
    check("lw14_lit", rd, 32'hABCD0000);

    txn(1'b0, 3'b010, 32'h10, 32'h0, 5, rd, er);
    txn(1'b1, 3'b010, 32'h3FC, 32'h0BADF00D, 2, rd, er);
    txn(1'b0, 3'b010, 32'h3FC, 32'h0, 0, rd, er);
    check("lw3fc_lit", rd, 32'h0BADF00D);

    txn(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 0, rd, er);
    txn(1'b0, 3'b010, 32'h20, 32'h0, 0, rd, er);

    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h20;
    req_wdata  = 32'h12345678;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    exp_rready = 1'b0;
    #5;
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_rsp_rdata", rsp_rdata, 32'd0);
    check("abort_rsp_err", 32'(rsp_err), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    #1 check("abort_idle", 32'(req_ready), 32'd1);
    exp_rready = 1'b1;
    exp_rvalid = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    txn(1'b0, 3'b010, 32'h20, 32'h0, 0, rd, er);
    check("lw20_lit", rd, 32'hCAFEF00D);

    repeat (2) @(posedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
